// File: rtl/note_player_pkg.sv
// Shared types and constants for the note-player control path.
// The period timer and its controller both import this package.
package note_player_pkg;

  // Period width shared with the note-player controller.
  localparam int unsigned PeriodW = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StDone  = 2'd2
  } timer_state_e;

endpackage

// File: rtl/note_period_timer_if.sv
// Controller <-> period timer link: load/done handshake, period config channel and debug view.
interface note_period_timer_if #(
  parameter int unsigned PERIOD_W = note_player_pkg::PeriodW
) ();

  logic                count_load;
  logic                count_done;
  logic                cfg_val;
  logic                cfg_rdy;
  logic [PERIOD_W-1:0] cfg_period;
  logic                busy;
  logic [PERIOD_W-1:0] cur_count;

  modport master (
    output count_load,
    output cfg_val,
    output cfg_period,
    input  count_done,
    input  cfg_rdy,
    input  busy,
    input  cur_count
  );

  modport slave (
    input  count_load,
    input  cfg_val,
    input  cfg_period,
    output count_done,
    output cfg_rdy,
    output busy,
    output cur_count
  );

endinterface

// File: rtl/note_tick_gen.sv
// Prescaler producing a one-cycle tick every PRESCALE enabled cycles.
// A synchronous clear restarts the phase so every interval starts on a full tick period.
module note_tick_gen #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned   CntW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] LastVal = CntW'(PRESCALE - 1);

  logic [CntW-1:0] presc_q, presc_d;
  logic            at_last;

  assign at_last = (presc_q == LastVal);

  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (enable) begin
      presc_d = at_last ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = enable && at_last;

endmodule

// File: rtl/note_period_timer.sv
// Note-period interval timer: counts a loaded period in prescaled ticks and holds done until
// the next load. A one-entry config buffer defers period changes to load boundaries.
module note_period_timer
  import note_player_pkg::*;
#(
  parameter int unsigned         PERIOD_W     = PeriodW,
  parameter int unsigned         PRESCALE     = 4,
  parameter logic [PERIOD_W-1:0] RESET_PERIOD = PERIOD_W'(10)
) (
  input logic               clk,
  input logic               rst,
  note_period_timer_if.slave bus
);

  timer_state_e        state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] pend_q, pend_d;
  logic                pend_full_q, pend_full_d;

  logic                tick;
  logic                cfg_xfer;
  logic [PERIOD_W-1:0] eff_period;

  note_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (bus.count_load),
    .enable (state_q == StCount),
    .tick   (tick)
  );

  assign cfg_xfer = bus.cfg_val && !pend_full_q;

  // A same-cycle offer beats the buffered one, which beats the held period.
  always_comb begin
    if (cfg_xfer) begin
      eff_period = bus.cfg_period;
    end else if (pend_full_q) begin
      eff_period = pend_q;
    end else begin
      eff_period = period_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;

    if (bus.count_load) begin
      period_d    = eff_period;
      pend_full_d = 1'b0;
      cnt_d       = eff_period;
      state_d     = (eff_period != '0) ? StCount : StDone;
    end else begin
      if (cfg_xfer) begin
        pend_d      = bus.cfg_period;
        pend_full_d = 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          // Nothing is running, so a buffered period can be adopted straight away.
          if (pend_full_q) begin
            period_d    = pend_q;
            pend_full_d = 1'b0;
          end
        end
        StCount: begin
          if (tick) begin
            if (cnt_q <= PERIOD_W'(1)) begin
              cnt_d   = '0;
              state_d = StDone;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      period_q    <= RESET_PERIOD;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end

  assign bus.count_done = (state_q == StDone);
  assign bus.busy       = (state_q == StCount);
  assign bus.cfg_rdy    = !pend_full_q;
  assign bus.cur_count  = cnt_q;

  a_done_busy_excl: assert property (@(posedge clk) disable iff (!rst)
    !(bus.busy && bus.count_done));

  a_count_nonzero: assert property (@(posedge clk) disable iff (!rst)
    (state_q == StCount) |-> (cnt_q != '0));

  a_done_zero: assert property (@(posedge clk) disable iff (!rst)
    (state_q == StDone) |-> (cnt_q == '0));

endmodule

// File: tb/tb_note_period_timer.sv
// Scoreboarded bench for note_period_timer: expected done cycles are queued at each load
// and compared when count_done rises.
module tb_note_period_timer;

  localparam int unsigned Presc = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   exp_q[$];

  note_period_timer_if #(.PERIOD_W(8)) bus ();

  note_period_timer #(
    .PERIOD_W     (8),
    .PRESCALE     (Presc),
    .RESET_PERIOD (8'd10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // All tasks start and end just after a falling edge.
  task automatic do_load(input bit with_cfg, input logic [7:0] p, input int exp_p,
                         input bit push);
    int t;
    t              = cyc;
    bus.count_load = 1'b1;
    bus.cfg_val    = with_cfg;
    bus.cfg_period = p;
    if (push) exp_q.push_back((exp_p == 0) ? t + 1 : t + exp_p * Presc + 1);
    @(negedge clk);
    bus.count_load = 1'b0;
    bus.cfg_val    = 1'b0;
  endtask

  task automatic offer_cfg(input logic [7:0] p);
    bus.cfg_val    = 1'b1;
    bus.cfg_period = p;
    @(negedge clk);
    bus.cfg_val    = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int n;
    int exp_c;
    n = 0;
    while (!bus.count_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: done seen at cycle %0d with no expectation queued", name, cyc);
    end else begin
      exp_c = exp_q.pop_front();
      if (!bus.count_done) begin
        miscompares++;
        $display("FAIL %s: done never rose, wanted at cycle %0d", name, exp_c);
      end else if (cyc !== exp_c) begin
        miscompares++;
        $display("FAIL %s: done rose at cycle %0d, wanted %0d", name, cyc, exp_c);
      end
    end
  endtask

  task automatic test_reset();
    rst            = 1'b0;
    bus.count_load = 1'b0;
    bus.cfg_val    = 1'b0;
    bus.cfg_period = '0;
    wait_cycles(3);
    vectors += 4;
    if (bus.count_done !== 1'b0) begin
      miscompares++; $display("FAIL reset_done: got %b want 0", bus.count_done);
    end
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    if (bus.cur_count !== 8'd0) begin
      miscompares++; $display("FAIL reset_count: got %0d want 0", bus.cur_count);
    end
    if (bus.cfg_rdy !== 1'b1) begin
      miscompares++; $display("FAIL reset_rdy: got %b want 1", bus.cfg_rdy);
    end
    rst = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_basic();
    int t;
    t = cyc;
    do_load(1'b0, 8'd0, 10, 1'b1);
    vectors += 2;
    if (bus.busy !== 1'b1) begin
      miscompares++; $display("FAIL basic_busy_first: got %b want 1", bus.busy);
    end
    if (bus.cur_count !== 8'd10) begin
      miscompares++; $display("FAIL basic_count_first: got %0d want 10", bus.cur_count);
    end
    while (cyc < t + 40) @(negedge clk);
    vectors += 3;
    if (bus.busy !== 1'b1) begin
      miscompares++; $display("FAIL basic_busy_last: got %b want 1", bus.busy);
    end
    if (bus.cur_count !== 8'd1) begin
      miscompares++; $display("FAIL basic_count_last: got %0d want 1", bus.cur_count);
    end
    if (bus.count_done !== 1'b0) begin
      miscompares++; $display("FAIL basic_done_early: got %b want 0", bus.count_done);
    end
    wait_done("basic_done");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.count_done !== 1'b1 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_hold: done=%b busy=%b want done=1 busy=0", bus.count_done, bus.busy);
      end
    end
  endtask

  task automatic test_cfg_idle();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    offer_cfg(8'd3);
    @(negedge clk);
    vectors++;
    if (bus.cfg_rdy !== 1'b1) begin
      miscompares++; $display("FAIL idle_rdy_drain: got %b want 1", bus.cfg_rdy);
    end
    do_load(1'b0, 8'd0, 3, 1'b1);
    vectors += 2;
    if (bus.cur_count !== 8'd3) begin
      miscompares++; $display("FAIL idle_count: got %0d want 3", bus.cur_count);
    end
    if (bus.cfg_rdy !== 1'b1) begin
      miscompares++; $display("FAIL idle_rdy_load: got %b want 1", bus.cfg_rdy);
    end
    wait_done("idle_cfg_done");
  endtask

  task automatic test_cfg_during_count();
    do_load(1'b1, 8'd10, 10, 1'b1);
    wait_cycles(5);
    vectors++;
    if (bus.cfg_rdy !== 1'b1) begin
      miscompares++; $display("FAIL count_rdy_before: got %b want 1", bus.cfg_rdy);
    end
    offer_cfg(8'd5);
    vectors += 2;
    if (bus.cfg_rdy !== 1'b0) begin
      miscompares++; $display("FAIL count_rdy_after: got %b want 0", bus.cfg_rdy);
    end
    if (bus.cur_count !== 8'd9) begin
      miscompares++; $display("FAIL count_untouched: got %0d want 9", bus.cur_count);
    end
    wait_done("count_cur_interval");
    wait_cycles(3);
    vectors++;
    if (bus.cfg_rdy !== 1'b0) begin
      miscompares++; $display("FAIL count_rdy_done: got %b want 0", bus.cfg_rdy);
    end
    do_load(1'b0, 8'd0, 5, 1'b1);
    vectors += 2;
    if (bus.cfg_rdy !== 1'b1) begin
      miscompares++; $display("FAIL count_rdy_reload: got %b want 1", bus.cfg_rdy);
    end
    if (bus.cur_count !== 8'd5) begin
      miscompares++; $display("FAIL count_new_period: got %0d want 5", bus.cur_count);
    end
    wait_done("count_next_interval");
  endtask

  task automatic test_zero();
    do_load(1'b1, 8'd0, 0, 1'b1);
    wait_done("zero_done");
    wait_cycles(3);
    vectors++;
    if (bus.count_done !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_hold: done=%b busy=%b want done=1 busy=0", bus.count_done, bus.busy);
    end
  endtask

  task automatic test_restart();
    do_load(1'b1, 8'd10, 10, 1'b0);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (bus.count_done !== 1'b0) begin
        miscompares++; $display("FAIL restart_quiet: got %b want 0", bus.count_done);
      end
      @(negedge clk);
    end
    do_load(1'b0, 8'd0, 10, 1'b1);
    wait_done("restart_done");
  endtask

  task automatic test_reset_mid();
    do_load(1'b0, 8'd0, 10, 1'b0);
    wait_cycles(5);
    offer_cfg(8'd7);
    wait_cycles(4);
    #2 rst = 1'b0;
    #1;
    vectors += 4;
    if (bus.count_done !== 1'b0) begin
      miscompares++; $display("FAIL mid_rst_done: got %b want 0", bus.count_done);
    end
    if (bus.cfg_rdy !== 1'b1) begin
      miscompares++; $display("FAIL mid_rst_rdy: got %b want 1", bus.cfg_rdy);
    end
    if (bus.cur_count !== 8'd0) begin
      miscompares++; $display("FAIL mid_rst_count: got %0d want 0", bus.cur_count);
    end
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_load(1'b0, 8'd0, 10, 1'b1);
    vectors++;
    if (bus.cur_count !== 8'd10) begin
      miscompares++; $display("FAIL mid_rst_period: got %0d want 10", bus.cur_count);
    end
    wait_done("mid_rst_done");
  endtask

  task automatic test_back_to_back();
    do_load(1'b0, 8'd0, 10, 1'b1);
    wait_done("b2b_first");
    do_load(1'b0, 8'd0, 10, 1'b1);
    vectors++;
    if (bus.count_done !== 1'b0) begin
      miscompares++; $display("FAIL b2b_drop: got %b want 0", bus.count_done);
    end
    wait_done("b2b_second");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_cfg_idle();
    test_cfg_during_count();
    test_zero();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/note_period_timer.md
Name: note_period_timer

Overview:
- Timing responder for the note-player control FSM.
- The controller pulses count_load to start a note-period interval. This block counts the interval in prescaled ticks and raises count_done until the next load.
- It holds the active note period. A one-entry val/rdy config buffer accepts a new period, which takes effect only at a load boundary or while idle, so an interval in progress is never corrupted.

Parameters:
- PERIOD_W, 8, width of the period and down-counter.
- PRESCALE, 4, clock cycles per count tick (>=1).
- RESET_PERIOD, 8'd10, period_reg value after reset.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- count_load  input  1  from controller: start or restart an interval.
- count_done  output  1  to controller: interval expired; held until next count_load.
- cfg_val  input  1  new period offered.
- cfg_rdy  output  1  config buffer empty.
- cfg_period  input  PERIOD_W  offered period value.
- busy  output  1  high in COUNT state.
- cur_count  output  PERIOD_W  remaining ticks (debug).

Behaviour:
- States: IDLE, COUNT, DONE.
- Reset (rst=0, asynchronous):
  - state=IDLE, count_done=0, busy=0, cur_count=0.
  - prescaler=0, pending buffer empty (cfg_rdy=1), period_reg=RESET_PERIOD.
  - Reset asserted mid-interval aborts it immediately. No done is produced.
- Config buffer:
  - cfg_rdy = !pend_full. A transfer occurs when cfg_val&&cfg_rdy.
  - Effective period for a load, in priority order: same-cycle cfg transfer, else pending entry, else period_reg. The effective value is written to period_reg and the pending entry is cleared.
  - In IDLE with pend_full and no load, the pending entry moves to period_reg on the next edge.
  - In COUNT or DONE, the pending entry waits for the next count_load.
- count_load=1 in any state, sampled at edge of cycle t:
  - cur_count = effective period P; prescaler=0.
  - Next state is COUNT if P!=0, else DONE.
  - count_done drops to 0 the cycle after a load, unless P=0.
  - A load while in COUNT restarts the interval. No done is produced for the aborted interval.
- COUNT:
  - Prescaler counts 0..PRESCALE-1. A tick occurs when prescaler==PRESCALE-1; the prescaler then wraps to 0.
  - On a tick, cur_count decrements. A tick with cur_count==1 sets cur_count=0 and state=DONE.
- Latency: count_done is first high in cycle t+P*PRESCALE+1. For P=0 it is high in cycle t+1.
- DONE:
  - count_done=1 and is held, with no auto-restart.
  - The state is left only by count_load or reset.
- Outputs:
  - count_done = (state==DONE). busy = (state==COUNT). Both are registered-state decodes with no combinational path from inputs.
- Width rules:
  - P is unsigned PERIOD_W.
  - The maximum interval is (2^PERIOD_W-1)*PRESCALE cycles.
  - cur_count never wraps below 0.

Decomposition:
- Shared package note_player_pkg:
  - state enum {IDLE, COUNT, DONE} for this block.
  - Default PERIOD_W constant shared with the controller.
- Sub-module note_tick_gen:
  - PRESCALE-cycle tick generator with synchronous clear (driven by count_load) and enable (state==COUNT).
  - Outputs a 1-cycle tick.

Test Plan:
- Reset, then load with PRESCALE=4 and period 10 -> count_done=0 until cycle t+41, then high and held for 20 further cycles; busy high t+1..t+40.
- cfg_period=3 accepted in IDLE, then load at cycle t -> period_reg=3; done first high at t+13; cfg_rdy=1 throughout.
- cfg_period=5 accepted during COUNT with period 10 -> current interval still ends at t+41; cfg_rdy=0 until next load; next interval ends 21 cycles after that load.
- cfg_period=0 and count_load in the same cycle t -> done high at t+1.
- Restart and reset checks:
  - Load, then reload 7 cycles later -> done fires 41 cycles after the second load only.
  - rst pulled low mid-COUNT -> count_done=0, cfg_rdy=1, cur_count=0 immediately; period_reg=10 afterwards.
- Back-to-back: load asserted in the cycle done first rises -> done falls next cycle; new interval timed correctly.
